// File: rtl/port_io_pkg.sv
// Shared types and helpers for the special-register port I/O sequencer.
package port_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } port_state_e;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int MAX_PA_WIDTH = 32;

  // Address driven on an idle port bus: all ones over the low 'width' bits.
  function automatic logic [MAX_PA_WIDTH-1:0] IDLE_ADDR(input int width);
    IDLE_ADDR = '0;
    for (int i = 0; i < MAX_PA_WIDTH; i++) begin
      if (i < width) IDLE_ADDR[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/port_io_timer.sv
// Saturating phase timer shared by the REQ and RELEASE phases.
module port_io_timer #(
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned         LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_WIDTH-1:0] LAST     = LAST_INT[TO_WIDTH-1:0];
  localparam logic                ARMED    = (TIMEOUT != 0);

  logic [TO_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ARMED && (count == LAST);

endmodule

// File: rtl/port_io_ctrl.sv
// Sequences one IN/OUT command at a time over a four-phase req/ack port bus.
// Handshake: req rises after accept and holds until ack is seen high (or the
// phase times out); req then stays low until ack is seen low (or times out).
module port_io_ctrl
  import port_io_pkg::*;
#(
  parameter int PA_WIDTH = 4,
  parameter int D_WIDTH  = 34,
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  input  logic                cmd_dir_i,
  input  logic [PA_WIDTH-1:0] cmd_addr_i,
  input  logic [D_WIDTH-1:0]  cmd_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [D_WIDTH-1:0]  rdata_o,
  output logic                in_req_o,
  output logic [PA_WIDTH-1:0] in_addr_o,
  input  logic [D_WIDTH-1:0]  in_data_i,
  input  logic                in_ack_i,
  output logic                out_req_o,
  output logic [PA_WIDTH-1:0] out_addr_o,
  output logic [D_WIDTH-1:0]  out_data_o,
  input  logic                out_ack_i,
  output port_state_e         dbg_state_o
);

  localparam logic [PA_WIDTH-1:0] IDLE_A = PA_WIDTH'(IDLE_ADDR(PA_WIDTH));

  port_state_e state, next_state;
  logic dir_q, err_q, dir_d, err_d;
  logic sel_ack, expired, timer_clear, timer_en;
  logic busy_d, done_d, timeout_d, in_req_d, out_req_d;
  logic [PA_WIDTH-1:0] in_addr_d, out_addr_d;
  logic [D_WIDTH-1:0]  out_data_d, rdata_d;

  assign sel_ack     = (dir_q == DIR_OUT) ? out_ack_i : in_ack_i;
  assign dbg_state_o = state;

  port_io_timer #(
    .TO_WIDTH(TO_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n_i(rst_n_i),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid_i) next_state = REQ;
      REQ:     if (sel_ack || expired) next_state = RELEASE;
      RELEASE: if (!sel_ack || expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dir_d       = dir_q;
    err_d       = err_q;
    in_req_d    = in_req_o;
    out_req_d   = out_req_o;
    in_addr_d   = in_addr_o;
    out_addr_d  = out_addr_o;
    out_data_d  = out_data_o;
    rdata_d     = rdata_o;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    busy_d      = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          dir_d = cmd_dir_i;
          err_d = 1'b0;
          if (cmd_dir_i == DIR_OUT) begin
            out_req_d  = 1'b1;
            out_addr_d = cmd_addr_i;
            out_data_d = cmd_data_i;
          end else begin
            in_req_d  = 1'b1;
            in_addr_d = cmd_addr_i;
          end
        end
      end
      REQ: begin
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        // Ack wins over a simultaneous expiry: the device answered in time.
        if (sel_ack) begin
          in_req_d    = 1'b0;
          out_req_d   = 1'b0;
          timer_clear = 1'b1;
          if (dir_q == DIR_IN) rdata_d = in_data_i;
        end else if (expired) begin
          in_req_d    = 1'b0;
          out_req_d   = 1'b0;
          err_d       = 1'b1;
          timer_clear = 1'b1;
        end
      end
      RELEASE: begin
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        if (!sel_ack) begin
          done_d    = !err_q;
          timeout_d = err_q;
        end else if (expired) begin
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dir_q      <= DIR_IN;
      err_q      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      in_req_o   <= 1'b0;
      out_req_o  <= 1'b0;
      in_addr_o  <= IDLE_A;
      out_addr_o <= IDLE_A;
      out_data_o <= '0;
      rdata_o    <= '0;
    end else begin
      dir_q      <= dir_d;
      err_q      <= err_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      timeout_o  <= timeout_d;
      in_req_o   <= in_req_d;
      out_req_o  <= out_req_d;
      in_addr_o  <= in_addr_d;
      out_addr_o <= out_addr_d;
      out_data_o <= out_data_d;
      rdata_o    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_port_io_ctrl.sv
// Bench for port_io_ctrl: a port-device responder with programmable ack delays
// and a transaction-level model of outcome, timing and register contents.
module tb_port_io_ctrl;
  import port_io_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n_i;
  logic        cmd_valid_i;
  logic        cmd_dir_i;
  logic [3:0]  cmd_addr_i;
  logic [33:0] cmd_data_i;
  logic        busy_o, done_o, timeout_o;
  logic [33:0] rdata_o;
  logic        in_req_o;
  logic [3:0]  in_addr_o;
  logic [33:0] in_data_i;
  logic        in_ack_i;
  logic        out_req_o;
  logic [3:0]  out_addr_o;
  logic [33:0] out_data_o;
  logic        out_ack_i;
  port_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_rdata;
  logic [3:0]  exp_in_addr, exp_out_addr;
  logic [33:0] exp_out_data;

  bit          pre_valid = 0;
  logic        pre_dir;
  logic [3:0]  pre_addr;
  logic [33:0] pre_data;

  port_io_ctrl #(
    .PA_WIDTH(4), .D_WIDTH(34), .TO_WIDTH(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_dir_i(cmd_dir_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rdata_o(rdata_o),
    .in_req_o(in_req_o), .in_addr_o(in_addr_o), .in_data_i(in_data_i), .in_ack_i(in_ack_i),
    .out_req_o(out_req_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .out_ack_i(out_ack_i), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] rnd34();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  // Issue one command; the device raises ack after 'a' cycles of req and drops
  // it 'b' cycles after req falls. Entered and left on a falling clock edge.
  task automatic do_cmd(input logic d, input logic [3:0] ad, input logic [33:0] dt,
                        input int a, input int b);
    int r_exp, s_exp, i_req, j_rel, req_cnt, lat, glitch;
    bit raised, ok_exp, seen_done, seen_to;
    logic sel_req, oth_req, ack_v;
    r_exp  = (a < TO) ? a + 1 : TO;
    s_exp  = (a >= TO) ? 1 : ((b < TO) ? b + 1 : TO);
    ok_exp = (a < TO) && (b < TO);
    cmd_valid_i = 1'b1;
    cmd_dir_i   = d;
    cmd_addr_i  = ad;
    cmd_data_i  = dt;
    @(negedge clk);
    sel_req = d ? out_req_o : in_req_o;
    check("accept", {busy_o, sel_req, done_o, timeout_o}, 4'b1100);
    if (pre_valid) begin
      cmd_dir_i  = pre_dir;
      cmd_addr_i = pre_addr;
      cmd_data_i = pre_data;
    end else begin
      cmd_valid_i = 1'b0;
    end
    if (d) begin
      exp_out_addr = ad;
      exp_out_data = dt;
    end else begin
      exp_in_addr = ad;
      if (a < TO) exp_rdata = dt;
    end
    i_req = 0; j_rel = 0; req_cnt = 0; lat = -1; glitch = 0;
    raised = 0; seen_done = 0; seen_to = 0;
    for (int n = 0; n < 4 * TO + 8; n++) begin
      sel_req = d ? out_req_o : in_req_o;
      oth_req = d ? in_req_o : out_req_o;
      if (done_o || timeout_o) begin
        lat = n; seen_done = done_o; seen_to = timeout_o;
        break;
      end
      if (sel_req) req_cnt++;
      if (oth_req || !busy_o) glitch++;
      if (sel_req && ((d ? out_addr_o : in_addr_o) !== ad)) glitch++;
      if (sel_req && d && (out_data_o !== dt)) glitch++;
      if (sel_req) begin
        ack_v = (i_req >= a);
        if (ack_v) raised = 1;
        i_req++;
      end else begin
        ack_v = raised && (j_rel < b);
        j_rel++;
      end
      if (d) begin
        out_ack_i = ack_v;
        in_ack_i  = 1'($urandom_range(0, 1));
        in_data_i = rnd34();
      end else begin
        in_ack_i  = ack_v;
        out_ack_i = 1'($urandom_range(0, 1));
        in_data_i = ack_v ? dt : rnd34();
      end
      @(negedge clk);
    end
    in_ack_i  = 1'b0;
    out_ack_i = 1'b0;
    check("req_cycles", req_cnt, r_exp);
    check("latency", lat, r_exp + s_exp);
    check("outcome", {seen_done, seen_to}, {ok_exp, !ok_exp});
    check("bus_glitch", glitch, 0);
    check("busy_end", busy_o, 1'b0);
    check("rdata", rdata_o, exp_rdata);
    check("port_regs", {in_addr_o, out_addr_o, out_data_o},
          {exp_in_addr, exp_out_addr, exp_out_data});
  endtask

  initial begin
    int n_bad, g, a, b;
    logic dd;
    rst_n_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_dir_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0;
    in_ack_i = 1'b0; out_ack_i = 1'b0; in_data_i = '0;
    exp_rdata = '0; exp_in_addr = 4'hF; exp_out_addr = 4'hF; exp_out_data = '0;

    // Asynchronous reset, checked before any rising edge
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_req", {in_req_o, out_req_o, busy_o, done_o, timeout_o}, 5'b0);
    check("rst_addr", {in_addr_o, out_addr_o}, 8'hFF);
    check("rst_data", {rdata_o, out_data_o}, 68'h0);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;

    // Acks while idle are ignored
    in_ack_i = 1'b1; out_ack_i = 1'b1;
    n_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_o || done_o || timeout_o || in_req_o || out_req_o) n_bad++;
    end
    check("idle_ack", n_bad, 0);
    in_ack_i = 1'b0; out_ack_i = 1'b0;
    @(negedge clk);

    // Directed transactions
    do_cmd(DIR_IN,  4'h3, 34'h2_DEAD_BEEF, 2, 1);
    do_cmd(DIR_OUT, 4'h5, 34'h1_0000_0001, 0, 0);
    do_cmd(DIR_IN,  4'h7, 34'h0_1111_2222, 100, 0);
    do_cmd(DIR_OUT, 4'hC, 34'h3_ABCD_0123, 0, 100);
    do_cmd(DIR_IN,  4'h1, 34'h1_5555_AAAA, TO - 1, TO - 1);

    // Back-to-back: next command held valid across the first one
    pre_valid = 1; pre_dir = DIR_IN; pre_addr = 4'h9; pre_data = 34'h0_0BAD_F00D;
    do_cmd(DIR_OUT, 4'hA, 34'h2_0F0F_F0F0, 1, 1);
    pre_valid = 0;
    do_cmd(DIR_IN, 4'h9, 34'h0_0BAD_F00D, 0, 0);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      dd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      b  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      do_cmd(dd, 4'($urandom_range(0, 15)), rnd34(), a, b);
      g = $urandom_range(0, 2);
      repeat (g) @(negedge clk);
    end

    // Reset while in the release phase with ack stuck high
    cmd_valid_i = 1'b1; cmd_dir_i = DIR_IN; cmd_addr_i = 4'h2; cmd_data_i = '0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    in_ack_i = 1'b1; in_data_i = 34'h3_1234_5678;
    @(negedge clk);
    check("mid_release", {busy_o, in_req_o, rdata_o}, {1'b1, 1'b0, 34'h3_1234_5678});
    #2 rst_n_i = 1'b0;
    #1;
    check("mid_reset", {busy_o, in_req_o, out_req_o, in_addr_o, rdata_o},
          {3'b000, 4'hF, 34'h0});
    @(negedge clk);
    rst_n_i = 1'b1;
    n_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_o || done_o || timeout_o || in_req_o) n_bad++;
    end
    check("post_reset_quiet", n_bad, 0);
    in_ack_i = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
